prio_update_rx: RTL and testbench
=================================

# prio_update_rx

Receive side of the priority-update interface inside the weighted round robin arbiter. Samples `prio_upt`/`prio_id`/`prio` writes, keeps the per-requester weight table, and presents it to the arbiter core. With the shadow option, updates are staged and committed atomically at arbitration-round boundaries, so weights never change mid-round.

## Interface
- `N_REQ`, 32: number of requesters; legal ids are 0..N_REQ-1 (1..32).
- `PRIO_W`, 4: weight width.
- `ID_W`, 5: requester id width.
- `RST_PRIO`, 4'd1: reset weight of every entry. Weight 0 means the requester is disabled.

- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `prio_upt`  in  1  update strobe; one write per cycle while high.
- `prio_id`  in  ID_W  target requester of the update.
- `prio`  in  PRIO_W  new weight.
- `round_done`  in  1  one-cycle pulse from the arbiter core at the end of a round.
- `rd_id`  in  ID_W  lookup id for the arbiter.
- `rd_prio`  out  PRIO_W  registered active weight of `rd_id`.
- `prio_vec`  out  N_REQ*PRIO_W  flat active table; entry i is at bits [i*PRIO_W +: PRIO_W].
- `upt_pending`  out  1  at least one staged update is not yet committed.
- `upt_err`  out  1  one-cycle pulse: the update targeted id >= N_REQ.

## Operation
- **Reset (`rst`=0, asynchronous):**
  - active and shadow entries = RST_PRIO; dirty bits = 0.
  - `rd_prio` = RST_PRIO; `upt_pending` = 0; `upt_err` = 0; FSM in IDLE.
- **Update acceptance:**
  - Update is sampled when `prio_upt`=1 at a rising edge.
  - `prio_id` >= N_REQ: update dropped, `upt_err`=1 for the following cycle, no table change.
  - No back-pressure; every cycle may carry an update.
- **Shadow mode (macro defined):**
  - A legal update writes `shadow[id]` and sets `dirty[id]`.
  - Same id written repeatedly before a commit: the last write wins.
  - On `round_done`, `active[i]` <= `shadow[i]` for every dirty i, and all dirty bits clear.
  - Update and `round_done` in the same cycle: the update is included in that commit (bypassed into active); its dirty bit stays 0.
- **FSM** (shadow mode only):
  - IDLE -> PEND on a legal update without `round_done`.
  - PEND -> IDLE on `round_done`.
  - PEND stays in PEND on further updates.
  - `upt_pending` = (state == PEND).
- **`rd_prio`:** `active[rd_id]` registered. `rd_id` >= N_REQ returns 0.
- **Width rules:** ids compare unsigned against N_REQ. No weight arithmetic in this block.

## Timing
- Update at edge N:
  - Direct mode: visible on `prio_vec` after edge N.
  - Shadow mode: visible after the first `round_done` edge >= N.
- `rd_prio` has 1-cycle latency. It reflects the active table before any same-edge write (read-before-write).
- `upt_err` is asserted for exactly the cycle after the offending edge.
- Reset asserted mid-round: all staged updates are discarded; table returns to RST_PRIO.
- `round_done` with no dirty entries: no change; FSM stays in IDLE.

## Configuration
- `PRIO_UPT_SHADOW_EN` defined:
  - Shadow bank, dirty bits and FSM are compiled in.
  - Commit happens on `round_done`.
- `PRIO_UPT_SHADOW_EN` undefined:
  - Legal updates write `active[id]` directly at the sampling edge.
  - `round_done` is ignored.
  - `upt_pending` is tied to 0.
  - No shadow storage is built.

## Structure
- Shared package `wrr_pkg` holds:
  - `PRIO_W`, `ID_W`, `RST_PRIO` constants;
  - `prio_t`, `prio_id_t` typedefs;
  - `prio_upt_state_e` enum (IDLE, PEND).
- One sub-module, `prio_shadow_bank`: shadow storage, dirty bits and commit-mask generation. It is instantiated only under `PRIO_UPT_SHADOW_EN`.
- Top level holds the active table, error check, FSM and read register.

## Test plan
- **Reset:** after release, all 32 `prio_vec` entries = 1, `rd_prio`=1, `upt_pending`=0, `upt_err`=0.
- **Direct update** (macro off): `prio_upt`=1, id=5, prio=9 -> `prio_vec[5]`=9 next cycle. `rd_id`=5 -> `rd_prio`=9 one cycle later.
- **Shadow commit:**
  - Stimulus: updates id=3 prio=7, then id=3 prio=12, no `round_done`.
  - Before commit: `prio_vec[3]`=1 and `upt_pending`=1.
  - After `round_done`: `prio_vec[3]`=12 and `upt_pending`=0.
- **Simultaneous update and commit:**
  - Stimulus: update id=31 prio=0 in the same cycle as `round_done`.
  - Response: `prio_vec[31]`=0 next cycle; `upt_pending`=0.
- **Illegal id** (N_REQ=20): update id=25 prio=4 -> one-cycle `upt_err`, table unchanged, `upt_pending` unchanged.
- **Reset mid-round:** update id=2 prio=8, then assert `rst` before `round_done` -> `prio_vec[2]`=1 and `upt_pending`=0 after release.

Source files
------------

// File: rtl/wrr_pkg.sv
// ============================================================================
//  Module      : wrr_pkg
//  Description : Shared constants and types for the weighted round robin
//                arbiter priority-update path.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package wrr_pkg;

    localparam int PRIO_W = 4;
    localparam int ID_W   = 5;

    typedef logic [PRIO_W-1:0] prio_t;
    typedef logic [ID_W-1:0]   prio_id_t;

    // Weight 0 disables a requester, so every entry starts enabled at 1.
    localparam prio_t RST_PRIO = 4'd1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        PEND = 1'b1
    } prio_upt_state_e;

endpackage

`default_nettype wire

// File: rtl/prio_update_rx_if.sv
// ============================================================================
//  Module      : prio_update_rx_if
//  Description : Priority-update write port, round boundary strobe, weight
//                lookup and active weight table of the WRR arbiter.
//                master = update source / arbiter core, slave = receiver.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface prio_update_rx_if
    import wrr_pkg::*;
#(
    parameter int N_REQ = 32
) ();

    logic                    prio_upt;
    prio_id_t                prio_id;
    prio_t                   prio;
    logic                    round_done;
    prio_id_t                rd_id;
    prio_t                   rd_prio;
    logic [N_REQ*PRIO_W-1:0] prio_vec;
    logic                    upt_pending;
    logic                    upt_err;

    modport master (
        output prio_upt, prio_id, prio, round_done, rd_id,
        input  rd_prio, prio_vec, upt_pending, upt_err
    );

    modport slave (
        input  prio_upt, prio_id, prio, round_done, rd_id,
        output rd_prio, prio_vec, upt_pending, upt_err
    );

endinterface

`default_nettype wire

// File: rtl/prio_shadow_bank.sv
// ============================================================================
//  Module      : prio_shadow_bank
//  Description : Staging bank for priority updates. Holds the shadow weights
//                and per-entry dirty bits, and produces the commit mask that
//                copies dirty entries into the active table at round end.
//                Instantiated by prio_update_rx only when PRIO_UPT_SHADOW_EN
//                is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module prio_shadow_bank
    import wrr_pkg::*;
#(
    parameter int N_REQ = 32
) (
    input  wire logic                    clk,
    input  wire logic                    rst,
    input  wire logic [N_REQ-1:0]        wr_sel,
    input  wire prio_t                   wr_prio,
    input  wire logic                    round_done,
    output logic      [N_REQ-1:0]        commit,
    output logic      [N_REQ*PRIO_W-1:0] shadow_vec
);

    prio_t            r_shadow [N_REQ];
    logic [N_REQ-1:0] r_dirty;

    // Stage writes; a write coinciding with round_done is bypassed into the
    // active table by the parent, so it never leaves a dirty bit behind.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_REQ; i++) r_shadow[i] <= RST_PRIO;
            r_dirty <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (wr_sel[i]) r_shadow[i] <= wr_prio;
            end
            if (round_done) r_dirty <= '0;
            else            r_dirty <= r_dirty | wr_sel;
        end
    end

    // Only dirty entries are copied at the round boundary.
    always_comb begin
        commit = round_done ? r_dirty : '0;
        shadow_vec = '0;
        for (int i = 0; i < N_REQ; i++) shadow_vec[i*PRIO_W +: PRIO_W] = r_shadow[i];
    end

endmodule

`default_nettype wire

// File: rtl/prio_update_rx.sv
// ============================================================================
//  Module      : prio_update_rx
//  Description : Receive side of the WRR priority-update interface. Checks
//                update ids, maintains the active weight table and serves a
//                registered weight lookup. With PRIO_UPT_SHADOW_EN defined,
//                updates are staged and committed atomically on round_done.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module prio_update_rx
    import wrr_pkg::*;
#(
    parameter int N_REQ = 32
) (
    input  wire logic       clk,
    input  wire logic       rst,
    prio_update_rx_if.slave bus
);

    localparam logic [ID_W:0] c_n_req = (ID_W+1)'(N_REQ);

    logic                    w_id_ok;
    logic                    w_upt_ok;
    logic [N_REQ-1:0]        w_sel;
    logic [N_REQ-1:0]        w_wr_en;
    logic [N_REQ*PRIO_W-1:0] w_wr_data;
    logic [N_REQ*PRIO_W-1:0] w_prio_vec;
    prio_t                   w_rd_prio;
    prio_t                   r_active [N_REQ];
    prio_t                   r_rd_prio;
    logic                    r_upt_err;

    // Ids are compared unsigned, one bit wider so N_REQ = 32 is representable.
    assign w_id_ok  = ({1'b0, bus.prio_id} < c_n_req);
    assign w_upt_ok = bus.prio_upt & w_id_ok;

    // One-hot decode of a legal update target.
    always_comb begin
        w_sel = '0;
        for (int i = 0; i < N_REQ; i++) w_sel[i] = w_upt_ok && (bus.prio_id == ID_W'(i));
    end

`ifdef PRIO_UPT_SHADOW_EN
    localparam logic [0:0] ST_IDLE = IDLE;
    localparam logic [0:0] ST_PEND = PEND;

    logic [N_REQ-1:0]        w_commit;
    logic [N_REQ*PRIO_W-1:0] w_shadow_vec;
    logic [0:0]              r_state;
    logic [0:0]              w_state_nxt;

    prio_shadow_bank #(.N_REQ(N_REQ)) u_shadow_bank (
        .clk        (clk),
        .rst        (rst),
        .wr_sel     (w_sel),
        .wr_prio    (bus.prio),
        .round_done (bus.round_done),
        .commit     (w_commit),
        .shadow_vec (w_shadow_vec)
    );

    // Commit dirty shadows; a same-cycle update overrides its own shadow copy.
    always_comb begin
        w_wr_en   = (w_sel & {N_REQ{bus.round_done}}) | w_commit;
        w_wr_data = w_shadow_vec;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_sel[i]) w_wr_data[i*PRIO_W +: PRIO_W] = bus.prio;
        end
    end

    // PEND tracks whether anything is staged for the next round boundary.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_upt_ok && !bus.round_done) w_state_nxt = ST_PEND;
            ST_PEND: if (bus.round_done)              w_state_nxt = ST_IDLE;
            default:                                  w_state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_state_nxt;
    end

    assign bus.upt_pending = (r_state == ST_PEND);
`else
    logic w_unused_round_done;

    assign w_unused_round_done = bus.round_done;

    // Legal updates go straight into the active table.
    always_comb begin
        w_wr_en   = w_sel;
        w_wr_data = {N_REQ{bus.prio}};
    end

    assign bus.upt_pending = 1'b0;
`endif

    // Active weight table.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_REQ; i++) r_active[i] <= RST_PRIO;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (w_wr_en[i]) r_active[i] <= w_wr_data[i*PRIO_W +: PRIO_W];
            end
        end
    end

    // Lookup mux; ids outside the table fall through to 0.
    always_comb begin
        w_rd_prio  = '0;
        w_prio_vec = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (bus.rd_id == ID_W'(i)) w_rd_prio = r_active[i];
            w_prio_vec[i*PRIO_W +: PRIO_W] = r_active[i];
        end
    end

    // Read register (pre-write table value) and one-cycle error pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_prio <= RST_PRIO;
            r_upt_err <= 1'b0;
        end else begin
            r_rd_prio <= w_rd_prio;
            r_upt_err <= bus.prio_upt & ~w_id_ok;
        end
    end

    assign bus.rd_prio  = r_rd_prio;
    assign bus.prio_vec = w_prio_vec;
    assign bus.upt_err  = r_upt_err;

endmodule

`default_nettype wire

// File: tb/tb_prio_update_rx.sv
// ============================================================================
//  Module      : tb_prio_update_rx
//  Description : Scoreboard bench for prio_update_rx. A 32-entry instance
//                covers reset, update, commit and mid-round reset; a 20-entry
//                instance covers out-of-range ids. Expectations follow the
//                PRIO_UPT_SHADOW_EN setting of the build.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_prio_update_rx;
    import wrr_pkg::*;

`ifdef PRIO_UPT_SHADOW_EN
    localparam bit SHADOW = 1'b1;
`else
    localparam bit SHADOW = 1'b0;
`endif

    // Observables addressed by the scoreboard.
    localparam int S_VEC32 = 0, S_RD32 = 1, S_PEND32 = 2, S_ERR32 = 3;
    localparam int S_VEC20 = 4, S_PEND20 = 5, S_ERR20 = 6, S_RD20 = 7;

    typedef struct {
        int          cyc;
        int          sel;
        int          idx;
        logic [3:0]  exp;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb[$];

    prio_update_rx_if #(.N_REQ(32)) bus32 ();
    prio_update_rx_if #(.N_REQ(20)) bus20 ();

    prio_update_rx #(.N_REQ(32)) dut (.clk(clk), .rst(rst), .bus(bus32));
    prio_update_rx #(.N_REQ(20)) dut20 (.clk(clk), .rst(rst), .bus(bus20));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [3:0] actual(int sel, int idx);
        case (sel)
            S_VEC32:  return bus32.prio_vec[idx*PRIO_W +: PRIO_W];
            S_RD32:   return bus32.rd_prio;
            S_PEND32: return {3'b000, bus32.upt_pending};
            S_ERR32:  return {3'b000, bus32.upt_err};
            S_VEC20:  return bus20.prio_vec[idx*PRIO_W +: PRIO_W];
            S_PEND20: return {3'b000, bus20.upt_pending};
            S_ERR20:  return {3'b000, bus20.upt_err};
            default:  return bus20.rd_prio;
        endcase
    endfunction

    // Queue an expectation to be checked after `dly` more rising edges.
    task automatic expect_at(input int dly, input int sel, input int idx,
                             input logic [3:0] val, input string name);
        exp_t e;
        e.cyc = cyc + dly; e.sel = sel; e.idx = idx; e.exp = val; e.name = name;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: on each falling edge, compare every entry due this cycle.
    always @(negedge clk) begin : mon
        int k;
        logic [3:0] a;
        k = 0;
        while (k < sb.size()) begin
            if (sb[k].cyc == cyc) begin
                a = actual(sb[k].sel, sb[k].idx);
                n_cmp++;
                if (a !== sb[k].exp) begin
                    n_bad++;
                    $display("FAIL %s[%0d] @cyc %0d: got %0d expected %0d",
                             sb[k].name, sb[k].idx, cyc, a, sb[k].exp);
                end
                sb.delete(k);
            end else begin
                k++;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        bus32.prio_upt = 0; bus32.prio_id = '0; bus32.prio = '0;
        bus32.round_done = 0; bus32.rd_id = '0;
        bus20.prio_upt = 0; bus20.prio_id = '0; bus20.prio = '0;
        bus20.round_done = 0; bus20.rd_id = '0;

        // Reset state
        repeat (3) tick();
        rst = 1'b1;
        for (int i = 0; i < 32; i++) expect_at(0, S_VEC32, i, 4'd1, "rst_vec");
        expect_at(0, S_RD32,   0, 4'd1, "rst_rd_prio");
        expect_at(0, S_PEND32, 0, 4'd0, "rst_pending");
        expect_at(0, S_ERR32,  0, 4'd0, "rst_err");
        expect_at(0, S_ERR20,  0, 4'd0, "rst_err20");
        tick();

        n_cmp++;
        if (bus32.upt_pending !== 1'b0) begin
            n_bad++;
            $display("FAIL direct_rst_pending: got %0b expected 0", bus32.upt_pending);
        end
        n_cmp++;
        if (bus32.upt_err !== 1'b0) begin
            n_bad++;
            $display("FAIL direct_rst_err: got %0b expected 0", bus32.upt_err);
        end
        n_cmp++;
        if (bus20.upt_err !== 1'b0) begin
            n_bad++;
            $display("FAIL direct_rst_err20: got %0b expected 0", bus20.upt_err);
        end
        n_cmp++;
        if (bus32.prio_vec[0 +: PRIO_W] !== 4'd1) begin
            n_bad++;
            $display("FAIL direct_rst_vec0: got %0d expected 1", bus32.prio_vec[0 +: PRIO_W]);
        end
        n_cmp++;
        if (bus32.rd_prio !== 4'd1) begin
            n_bad++;
            $display("FAIL direct_rst_rd: got %0d expected 1", bus32.rd_prio);
        end

        // id 5 <- 9, with read-before-write on rd_prio
        bus32.prio_upt = 1; bus32.prio_id = 5'd5; bus32.prio = 4'd9; bus32.rd_id = 5'd5;
        expect_at(1, S_VEC32,  5, SHADOW ? 4'd1 : 4'd9, "upd5_vec");
        expect_at(1, S_RD32,   0, 4'd1, "upd5_rd_old");
        expect_at(2, S_RD32,   0, SHADOW ? 4'd1 : 4'd9, "upd5_rd_new");
        expect_at(1, S_PEND32, 0, SHADOW ? 4'd1 : 4'd0, "upd5_pend");
        tick();
        bus32.prio_upt = 0;
        tick();
        bus32.round_done = 1;
        expect_at(1, S_VEC32,  5, 4'd9, "commit5_vec");
        expect_at(1, S_PEND32, 0, 4'd0, "commit5_pend");
        expect_at(1, S_RD32,   0, SHADOW ? 4'd1 : 4'd9, "commit5_rd_old");
        expect_at(2, S_RD32,   0, 4'd9, "commit5_rd_new");
        tick();
        bus32.round_done = 0;
        tick();

        // id 3 <- 7 then 12; last write wins
        bus32.prio_upt = 1; bus32.prio_id = 5'd3; bus32.prio = 4'd7;
        expect_at(1, S_VEC32,  3, SHADOW ? 4'd1 : 4'd7, "upd3a_vec");
        expect_at(1, S_PEND32, 0, SHADOW ? 4'd1 : 4'd0, "upd3a_pend");
        tick();
        bus32.prio = 4'd12;
        expect_at(1, S_VEC32,  3, SHADOW ? 4'd1 : 4'd12, "upd3b_vec");
        expect_at(1, S_PEND32, 0, SHADOW ? 4'd1 : 4'd0, "upd3b_pend");
        tick();
        bus32.prio_upt = 0;
        expect_at(1, S_VEC32, 3, SHADOW ? 4'd1 : 4'd12, "hold3_vec");
        tick();
        bus32.round_done = 1;
        expect_at(1, S_VEC32,  3, 4'd12, "commit3_vec");
        expect_at(1, S_PEND32, 0, 4'd0, "commit3_pend");
        tick();

        // round_done with nothing staged
        expect_at(1, S_VEC32,  3, 4'd12, "empty_commit_vec");
        expect_at(1, S_PEND32, 0, 4'd0, "empty_commit_pend");
        tick();
        bus32.round_done = 0;
        tick();

        // id 31 <- 0 in the same cycle as round_done
        bus32.prio_upt = 1; bus32.prio_id = 5'd31; bus32.prio = 4'd0;
        bus32.round_done = 1; bus32.rd_id = 5'd31;
        expect_at(1, S_VEC32,  31, 4'd0, "bypass31_vec");
        expect_at(1, S_PEND32, 0, 4'd0, "bypass31_pend");
        expect_at(1, S_VEC32,  3, 4'd12, "bypass31_vec3");
        expect_at(2, S_RD32,   0, 4'd0, "bypass31_rd");
        expect_at(2, S_PEND32, 0, 4'd0, "bypass31_pend2");
        expect_at(1, S_ERR32,  0, 4'd0, "bypass31_err");
        tick();
        bus32.prio_upt = 0; bus32.round_done = 0;
        tick();

        // 20-entry instance: legal update then illegal id 25
        bus20.prio_upt = 1; bus20.prio_id = 5'd1; bus20.prio = 4'd6;
        expect_at(1, S_VEC20,  1, SHADOW ? 4'd1 : 4'd6, "upd20_vec1");
        expect_at(1, S_PEND20, 0, SHADOW ? 4'd1 : 4'd0, "upd20_pend");
        tick();
        bus20.prio_id = 5'd25; bus20.prio = 4'd4; bus20.rd_id = 5'd25;
        expect_at(1, S_ERR20,  0, 4'd1, "illegal_err");
        expect_at(1, S_PEND20, 0, SHADOW ? 4'd1 : 4'd0, "illegal_pend");
        expect_at(1, S_VEC20,  1, SHADOW ? 4'd1 : 4'd6, "illegal_vec1");
        expect_at(1, S_VEC20,  9, 4'd1, "illegal_vec9");
        expect_at(1, S_VEC20,  19, 4'd1, "illegal_vec19");
        expect_at(2, S_ERR20,  0, 4'd0, "illegal_err_end");
        expect_at(2, S_RD20,   0, 4'd0, "illegal_rd");
        tick();
        bus20.prio_upt = 0;
        tick();

        // Reset in the middle of a round
        bus32.prio_upt = 1; bus32.prio_id = 5'd2; bus32.prio = 4'd8;
        expect_at(1, S_VEC32,  2, SHADOW ? 4'd1 : 4'd8, "midrst_vec_pre");
        expect_at(1, S_PEND32, 0, SHADOW ? 4'd1 : 4'd0, "midrst_pend_pre");
        tick();
        bus32.prio_upt = 0;
        @(negedge clk);
        #1;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        expect_at(0, S_VEC32,  2, 4'd1, "midrst_vec2");
        expect_at(0, S_VEC32,  3, 4'd1, "midrst_vec3");
        expect_at(0, S_VEC32,  31, 4'd1, "midrst_vec31");
        expect_at(0, S_PEND32, 0, 4'd0, "midrst_pend");
        expect_at(0, S_RD32,   0, 4'd1, "midrst_rd");
        expect_at(0, S_PEND20, 0, 4'd0, "midrst_pend20");
        expect_at(0, S_VEC20,  1, 4'd1, "midrst_vec20");
        repeat (4) tick();

        n_cmp++;
        if (bus32.prio_vec[2*PRIO_W +: PRIO_W] !== 4'd1) begin
            n_bad++;
            $display("FAIL direct_midrst_vec2: got %0d expected 1",
                     bus32.prio_vec[2*PRIO_W +: PRIO_W]);
        end
        n_cmp++;
        if (bus32.upt_pending !== 1'b0) begin
            n_bad++;
            $display("FAIL direct_midrst_pend: got %0b expected 0", bus32.upt_pending);
        end
        n_cmp++;
        if (bus32.prio_vec[31*PRIO_W +: PRIO_W] !== 4'd1) begin
            n_bad++;
            $display("FAIL direct_midrst_vec31: got %0d expected 1",
                     bus32.prio_vec[31*PRIO_W +: PRIO_W]);
        end
        n_cmp++;
        if (bus20.prio_vec[19*PRIO_W +: PRIO_W] !== 4'd1) begin
            n_bad++;
            $display("FAIL direct_midrst_vec20_19: got %0d expected 1",
                     bus20.prio_vec[19*PRIO_W +: PRIO_W]);
        end

        // Anything still queued was never checked.
        while (sb.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: check at cyc %0d never reached, expected %0d",
                     sb[0].name, sb[0].cyc, sb[0].exp);
            void'(sb.pop_front());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
